// File: rtl/s2p_frame_rx.sv
// s2p_frame_rx: serial-to-parallel frame receiver.
// A frame is an address phase (REGSEL=1, MSB first) followed by a data
// phase (REGSEL=0, LSB first). The completed frame is presented on
// SLAVE_ADDR/DATA_OUT with a one-hot WR_SEL slave decode.
//
// Optional feature, enabled by defining the macro S2P_ADDR_RANGE_CHK_EN:
//   a completed frame whose address is >= NUM_SLAVES is rejected as a
//   frame error and its contents are never presented. When the macro is
//   undefined, such a frame is presented with VALID=1 and an all-zero WR_SEL.
//
// Output qualification: VALID is a level without any back-pressure.
// While VALID=1, SLAVE_ADDR, DATA_OUT and WR_SEL describe one completed
// frame and remain stable until the first address edge of the next frame
// (which drops VALID) or a reset. There is no ready input; a consumer
// must sample while VALID=1.
module s2p_frame_rx #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 30,
    parameter int NUM_SLAVES = 23
) (
    input  logic                  SCLK,
    input  logic                  RST,
    input  logic                  GRST,
    input  logic                  REGSEL,
    input  logic                  SIN,
    output logic [ADDR_W-1:0]     SLAVE_ADDR,
    output logic [DATA_W-1:0]     DATA_OUT,
    output logic [NUM_SLAVES-1:0] WR_SEL,
    output logic                  VALID,
    output logic                  FRAME_ERR,
    output logic [1:0]            fsm_state
);

    localparam int DCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Registered state
    logic [1:0]            state;
    logic [ADDR_W-1:0]     addr_sr;
    logic [2:0]            addr_cnt;
    logic [DATA_W-1:0]     data_sr;
    logic [DCNT_W-1:0]     data_cnt;

    // Next-state values
    logic [1:0]            state_d;
    logic [ADDR_W-1:0]     addr_sr_d;
    logic [2:0]            addr_cnt_d;
    logic [DATA_W-1:0]     data_sr_d;
    logic [DCNT_W-1:0]     data_cnt_d;
    logic [ADDR_W-1:0]     slave_addr_d;
    logic [DATA_W-1:0]     data_out_d;
    logic [NUM_SLAVES-1:0] wr_sel_d;
    logic                  valid_d;
    logic                  frame_err_d;

    // Helper terms
    logic [ADDR_W-1:0]     addr_shift;
    logic [2:0]            addr_cnt_inc;
    logic                  addr_len_ok;
    logic [DATA_W-1:0]     data_ins;
    logic                  data_last;
    logic                  addr_in_range;
    logic [NUM_SLAVES-1:0] sel_dec;

    assign fsm_state = state;

    // Address shifting, saturating bit count and data-bit insertion
    always_comb begin
        addr_shift   = ADDR_W'({addr_sr, SIN});
        addr_cnt_inc = (addr_cnt == 3'd7) ? 3'd7 : addr_cnt + 3'd1;
        addr_len_ok  = (int'(addr_cnt) == ADDR_W);
        data_ins     = data_sr;
        data_ins[data_cnt] = SIN;
        data_last    = (data_cnt == DCNT_W'(DATA_W - 1));
    end

    // One-hot slave decode of the collected address; zero when out of range
    always_comb begin
        addr_in_range = (int'(addr_sr) < NUM_SLAVES);
        sel_dec       = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(addr_sr) == i) begin
                sel_dec[i] = 1'b1;
            end
        end
    end

    // Frame FSM: next-state and output-register update rules
    always_comb begin
        state_d      = state;
        addr_sr_d    = addr_sr;
        addr_cnt_d   = addr_cnt;
        data_sr_d    = data_sr;
        data_cnt_d   = data_cnt;
        slave_addr_d = SLAVE_ADDR;
        data_out_d   = DATA_OUT;
        wr_sel_d     = WR_SEL;
        valid_d      = VALID;
        frame_err_d  = FRAME_ERR;

        case (state)
            S_IDLE, S_DONE: begin
                // REGSEL=0 edges are ignored here so a completed frame stays
                // visible until the next frame starts.
                if (REGSEL) begin
                    addr_sr_d   = ADDR_W'(SIN);
                    addr_cnt_d  = 3'd1;
                    data_cnt_d  = '0;
                    valid_d     = 1'b0;
                    wr_sel_d    = '0;
                    frame_err_d = 1'b0;
                    state_d     = S_ADDR;
                end
            end

            S_ADDR: begin
                if (REGSEL) begin
                    addr_sr_d  = addr_shift;
                    addr_cnt_d = addr_cnt_inc;
                end else if (addr_len_ok) begin
                    // The edge that ends the address phase already carries
                    // data bit 0.
                    data_sr_d    = data_sr;
                    data_sr_d[0] = SIN;
                    data_cnt_d   = DCNT_W'(1);
                    state_d      = S_DATA;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            S_DATA: begin
                if (REGSEL) begin
                    // Truncated data phase: flag it and treat this edge as
                    // the first address bit of a new frame.
                    frame_err_d = 1'b1;
                    valid_d     = 1'b0;
                    addr_sr_d   = ADDR_W'(SIN);
                    addr_cnt_d  = 3'd1;
                    data_cnt_d  = '0;
                    state_d     = S_ADDR;
                end else begin
                    data_sr_d  = data_ins;
                    data_cnt_d = data_cnt + DCNT_W'(1);
                    if (data_last) begin
                        // Frame complete on this very edge; SCLK may stop now.
                        data_cnt_d = '0;
`ifdef S2P_ADDR_RANGE_CHK_EN
                        if (!addr_in_range) begin
                            frame_err_d = 1'b1;
                            valid_d     = 1'b0;
                            wr_sel_d    = '0;
                            state_d     = S_IDLE;
                        end else begin
                            slave_addr_d = addr_sr;
                            data_out_d   = data_ins;
                            wr_sel_d     = sel_dec;
                            valid_d      = 1'b1;
                            frame_err_d  = 1'b0;
                            state_d      = S_DONE;
                        end
`else
                        slave_addr_d = addr_sr;
                        data_out_d   = data_ins;
                        wr_sel_d     = sel_dec;
                        valid_d      = 1'b1;
                        state_d      = S_DONE;
                        // An out-of-range frame neither raises nor clears
                        // the error flag; a well-formed one clears it.
                        if (addr_in_range) begin
                            frame_err_d = 1'b0;
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers: async RST, then synchronous GRST, then FSM
    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            addr_sr    <= '0;
            addr_cnt   <= '0;
            data_sr    <= '0;
            data_cnt   <= '0;
            SLAVE_ADDR <= '0;
            DATA_OUT   <= '0;
            WR_SEL     <= '0;
            VALID      <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else if (GRST) begin
            state      <= S_IDLE;
            addr_sr    <= '0;
            addr_cnt   <= '0;
            data_sr    <= '0;
            data_cnt   <= '0;
            SLAVE_ADDR <= '0;
            DATA_OUT   <= '0;
            WR_SEL     <= '0;
            VALID      <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state      <= state_d;
            addr_sr    <= addr_sr_d;
            addr_cnt   <= addr_cnt_d;
            data_sr    <= data_sr_d;
            data_cnt   <= data_cnt_d;
            SLAVE_ADDR <= slave_addr_d;
            DATA_OUT   <= data_out_d;
            WR_SEL     <= wr_sel_d;
            VALID      <= valid_d;
            FRAME_ERR  <= frame_err_d;
        end
    end

endmodule

// File: doc/s2p_frame_rx.md
S2P_FRAME_RX -- requirements
Module: s2p_frame_rx

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, slave-address width.
REQ-002 SHALL have parameter DATA_W, default 30, data-word width.
REQ-003 SHALL have parameter NUM_SLAVES, default 23, number of addressable slaves.
REQ-004 SHALL have port SCLK  input  1  serial clock; the only clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port GRST  input  1  global chip reset, active-high, sampled synchronously on SCLK.
REQ-007 SHALL have port REGSEL  input  1  1 = address phase, 0 = data phase or idle.
REQ-008 SHALL have port SIN  input  1  serial data, stable around rising SCLK.
REQ-009 SHALL have port SLAVE_ADDR  output  ADDR_W  address of the last completed frame.
REQ-010 SHALL have port DATA_OUT  output  DATA_W  data word of the last completed frame.
REQ-011 SHALL have port WR_SEL  output  NUM_SLAVES  one-hot slave select; nonzero only while VALID=1.
REQ-012 SHALL have port VALID  output  1  level: DATA_OUT, SLAVE_ADDR and WR_SEL hold a completed frame.
REQ-013 SHALL have port FRAME_ERR  output  1  sticky: last frame was malformed.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-015 IDLE: REGSEL=1 at an edge SHALL shift in SIN as address bit 1, clear VALID and FRAME_ERR, and go to ADDR.
REQ-016 ADDR: while REGSEL=1, each edge SHALL shift SIN into the address register, MSB first (shift left), and increment a 3-bit bit counter that saturates at 7.
REQ-017 ADDR with REGSEL=0 SHALL check the counter: exactly ADDR_W bits -> go to DATA; that same edge SHALL sample SIN as data bit 0. Any other count -> set FRAME_ERR and go to IDLE.
REQ-018 DATA: each edge SHALL store SIN at data bit index n, LSB first, n = 0..DATA_W-1.
REQ-019 On the edge that captures bit DATA_W-1, SHALL load DATA_OUT and SLAVE_ADDR, decode WR_SEL, set VALID and go to DONE. Zero latency: no further SCLK edge is needed, because upstream gates SCLK off after the last bit.
REQ-020 DATA with REGSEL=1 before DATA_W bits SHALL set FRAME_ERR, leave VALID at 0, and restart in ADDR, taking the current SIN as address bit 1.
REQ-021 DONE: REGSEL=0 edges SHALL be ignored with outputs held. REGSEL=1 SHALL behave as in REQ-015.
REQ-022 DATA_OUT and SLAVE_ADDR SHALL change only on a frame-complete edge. Partial frames SHALL never be visible.
REQ-023 WR_SEL SHALL be bit SLAVE_ADDR when VALID=1 and SLAVE_ADDR < NUM_SLAVES, otherwise all zero.

Reset
REQ-024 RST=0 SHALL asynchronously force IDLE, clear counters and shift registers, and set SLAVE_ADDR=0, DATA_OUT=0, WR_SEL=0, VALID=0, FRAME_ERR=0.
REQ-025 GRST=1 at an edge SHALL apply the same values synchronously and SHALL take precedence over all FSM activity.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no VALID pulse.

Configuration
REQ-027 Macro S2P_ADDR_RANGE_CHK_EN:
- Defined: a completed frame with SLAVE_ADDR >= NUM_SLAVES SHALL set FRAME_ERR, keep VALID=0, and keep the previous DATA_OUT.
- Undefined: such a frame SHALL set VALID=1 with WR_SEL all zero and FRAME_ERR unchanged.

Verification
REQ-028 Reset, then GRST=1 for 40 edges and released; addr 5'd10 (01010) sent under REGSEL=1, then 30 bits of 35 LSB first -> VALID=1, SLAVE_ADDR=10, DATA_OUT=35, WR_SEL=1<<10, FRAME_ERR=0.
REQ-029 Back-to-back frames (22, 2) then (16, 100) -> VALID drops on the first address edge of frame 2; after frame 2: SLAVE_ADDR=16, DATA_OUT=100, WR_SEL=1<<16.
REQ-030 REGSEL=1 for only 4 edges, then data bits -> FRAME_ERR=1, VALID=0, DATA_OUT unchanged.
REQ-031 Address 10, then REGSEL raised after 12 data bits -> FRAME_ERR=1; the following full frame (22, 2) completes with VALID=1 and FRAME_ERR cleared.
REQ-032 Address 5'd30, data 7 -> with macro: FRAME_ERR=1, VALID=0; without macro: VALID=1, WR_SEL=0, DATA_OUT=7.
REQ-033 RST pulsed low after 15 data bits -> all outputs zero immediately; no VALID on later edges until a new full frame.
